// File: rtl/mant_mul_seq_if.sv
// Handshake and data bundle between a requester and the sequential mantissa multiplier.
interface mant_mul_seq_if;
    logic         req;
    logic [52:0]  a;
    logic [52:0]  b;
    logic         busy;
    logic         done;
    logic [105:0] prod;

    modport master (output req, a, b, input busy, done, prod);
    modport slave  (input req, a, b, output busy, done, prod);
endinterface

// File: rtl/mant_mul_seq.sv
// 53x53 significand multiplier built from one 27x27 multiplier reused over four cycles.
//  state | meaning
//  IDLE  | waiting for req, operands captured on acceptance
//  M0    | issue lo*lo
//  M1    | issue lo*hi, accumulate lo*lo
//  M2    | issue hi*lo, accumulate lo*hi << 26
//  M3    | issue hi*hi, accumulate hi*lo << 26
//  M4    | write prod = acc + hi*hi << 52, raise done
module mul0 (
    input  logic        clk,
    input  logic        en,
    input  logic [26:0] x,
    input  logic [26:0] y,
    output logic [53:0] p
);
    always_ff @(posedge clk) begin
        if (en) p <= {27'b0, x} * {27'b0, y};
    end
endmodule

module mant_mul_seq (
    input  logic           clk,
    input  logic           reset,
    mant_mul_seq_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4} state_t;

    state_t        state;
    logic [52:0]   a_q;
    logic [52:0]   b_q;
    logic [105:0]  acc;
    logic          en;
    logic [26:0]   mul_x;
    logic [26:0]   mul_y;
    logic [53:0]   mul_p;
    logic [105:0]  mul_ext;

    wire [26:0] a_lo = {1'b0, a_q[25:0]};
    wire [26:0] a_hi = a_q[52:26];
    wire [26:0] b_lo = {1'b0, b_q[25:0]};
    wire [26:0] b_hi = b_q[52:26];

    always_comb begin
        en    = 1'b0;
        mul_x = a_lo;
        mul_y = b_lo;
        case (state)
            M0: begin en = 1'b1; mul_x = a_lo; mul_y = b_lo; end
            M1: begin en = 1'b1; mul_x = a_lo; mul_y = b_hi; end
            M2: begin en = 1'b1; mul_x = a_hi; mul_y = b_lo; end
            M3: begin en = 1'b1; mul_x = a_hi; mul_y = b_hi; end
            default: ;
        endcase
    end

    mul0 u_mul0 (
        .clk (clk),
        .en  (en),
        .x   (mul_x),
        .y   (mul_y),
        .p   (mul_p)
    );

    assign mul_ext = {52'b0, mul_p};

    // Each partial product is available one state after it was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.prod <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        acc      <= '0;
                        bus.busy <= 1'b1;
                        state    <= M0;
                    end
                end
                M0: state <= M1;
                M1: begin
                    acc   <= acc + mul_ext;
                    state <= M2;
                end
                M2: begin
                    acc   <= acc + (mul_ext << 26);
                    state <= M3;
                end
                M3: begin
                    acc   <= acc + (mul_ext << 26);
                    state <= M4;
                end
                M4: begin
                    bus.prod <= acc + (mul_ext << 52);
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed and random checks of the sequential mantissa multiplier's latency and product.
module tb_mant_mul_seq;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    localparam logic [52:0] MAX53 = {53{1'b1}};

    mant_mul_seq_if bus ();

    mant_mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [105:0] ref_mul(input logic [52:0] x, input logic [52:0] y);
        return {53'b0, x} * {53'b0, y};
    endfunction

    function automatic logic [52:0] rnd53();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[52:0];
    endfunction

    // Issues one request and returns the cycle in which done appeared (-1 if never).
    task automatic do_op(input logic [52:0] x, input logic [52:0] y,
                         output int lat, output logic [105:0] p);
        lat    = -1;
        p      = '0;
        bus.a  = x;
        bus.b  = y;
        bus.req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            bus.req = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
                p   = bus.prod;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bus.req = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.prod !== 106'd0) begin
            n_err++;
            $display("FAIL reset_state busy=%b done=%b prod=%h required 0/0/0", bus.busy, bus.done, bus.prod);
        end
    endtask

    task automatic test_timing();
        logic [105:0] exp_p;
        exp_p   = 106'd1 << 104;
        bus.a   = 53'd1 << 52;
        bus.b   = 53'd1 << 52;
        bus.req = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            bus.req = 1'b0;
            n_cmp++;
            if (bus.busy !== (c >= 1 && c <= 5)) begin
                n_err++;
                $display("FAIL timing_busy cycle %0d got %b required %b", c, bus.busy, (c <= 5));
            end
            n_cmp++;
            if (bus.done !== (c == 6)) begin
                n_err++;
                $display("FAIL timing_done cycle %0d got %b required %b", c, bus.done, (c == 6));
            end
            if (c == 6) begin
                n_cmp++;
                if (bus.prod !== exp_p) begin
                    n_err++;
                    $display("FAIL timing_prod got %h required %h", bus.prod, exp_p);
                end
            end
        end
    endtask

    task automatic test_max();
        int lat;
        logic [105:0] p;
        logic [105:0] exp_p;
        exp_p = ~106'd0 - (106'd1 << 54) + 106'd2;
        do_op(MAX53, MAX53, lat, p);
        n_cmp++;
        if (lat != 6 || p !== exp_p) begin
            n_err++;
            $display("FAIL max_operands lat=%0d prod=%h required lat=6 prod=%h", lat, p, exp_p);
        end
    endtask

    task automatic test_cross_and_random();
        int lat;
        logic [105:0] p;
        logic [52:0] x;
        logic [52:0] y;
        logic [55:0] wide;
        int errs;
        wide = 56'h1FFFFFF_F000000;
        x = wide[52:0];
        y = 53'h3FFFFFF;
        do_op(x, y, lat, p);
        n_cmp++;
        if (lat != 6 || p !== ref_mul(x, y)) begin
            n_err++;
            $display("FAIL field_cross lat=%0d prod=%h required %h", lat, p, ref_mul(x, y));
        end
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            x = rnd53();
            y = rnd53();
            if (i % 4 == 0) x[52] = 1'b1;
            do_op(x, y, lat, p);
            n_cmp++;
            if (lat != 6 || p !== ref_mul(x, y)) begin
                n_err++;
                if (errs < 5)
                    $display("FAIL random_%0d a=%h b=%h lat=%0d prod=%h required %h", i, x, y, lat, p, ref_mul(x, y));
                errs++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [52:0] av [0:18];
        logic [52:0] bv [0:18];
        logic [105:0] exp_p;
        for (int i = 0; i <= 18; i++) begin
            av[i] = rnd53() | (53'd1 << 52);
            bv[i] = rnd53() | (53'd1 << 52);
        end
        bus.a   = av[0];
        bus.b   = bv[0];
        bus.req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            n_cmp++;
            if (bus.done !== (c == 6 || c == 12 || c == 18)) begin
                n_err++;
                $display("FAIL b2b_done cycle %0d got %b", c, bus.done);
            end
            if (c == 6 || c == 12 || c == 18) begin
                exp_p = ref_mul(av[c-6], bv[c-6]);
                n_cmp++;
                if (bus.prod !== exp_p) begin
                    n_err++;
                    $display("FAIL b2b_prod cycle %0d got %h required %h", c, bus.prod, exp_p);
                end
            end
            if (c == 11) begin
                exp_p = ref_mul(av[0], bv[0]);
                n_cmp++;
                if (bus.prod !== exp_p) begin
                    n_err++;
                    $display("FAIL b2b_hold cycle 11 got %h required %h", bus.prod, exp_p);
                end
            end
            bus.a = av[c];
            bus.b = bv[c];
            if (c == 18) bus.req = 1'b0;
        end
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_drain busy got %b required 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        logic [52:0] x;
        logic [52:0] y;
        logic [105:0] exp_p;
        int dones;
        x = 53'h1ABCDEF0123456;
        y = 53'h1234567ABCDEF1;
        bus.a   = MAX53;
        bus.b   = MAX53;
        bus.req = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            bus.req = 1'b0;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.prod !== 106'd0 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_c4 busy=%b done=%b prod=%h required 0/0/0", bus.busy, bus.done, bus.prod);
        end
        bus.a   = x;
        bus.b   = y;
        bus.req = 1'b1;
        dones = 0;
        for (int c = 5; c <= 10; c++) begin
            tick();
            bus.req = 1'b0;
            if (bus.done === 1'b1 && c != 10) dones++;
        end
        exp_p = ref_mul(x, y);
        n_cmp++;
        if (dones != 0 || bus.done !== 1'b1 || bus.prod !== exp_p) begin
            n_err++;
            $display("FAIL reset_mid_restart early_dones=%0d done_c10=%b prod=%h required 0/1/%h",
                     dones, bus.done, bus.prod, exp_p);
        end
    endtask

    task automatic test_reset_wins();
        int dones;
        int busies;
        tick();
        bus.a   = MAX53;
        bus.b   = MAX53;
        bus.req = 1'b1;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        bus.req = 1'b0;
        dones  = 0;
        busies = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done === 1'b1) dones++;
            if (bus.busy === 1'b1) busies++;
            tick();
        end
        n_cmp++;
        if (dones != 0 || busies != 0 || bus.prod !== 106'd0) begin
            n_err++;
            $display("FAIL reset_wins dones=%0d busy_cycles=%0d prod=%h required 0/0/0", dones, busies, bus.prod);
        end
    endtask

    task automatic test_zero_toggle();
        int lat;
        logic [105:0] p;
        lat = -1;
        p   = '1;
        bus.a   = '0;
        bus.b   = MAX53;
        bus.req = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            bus.req = 1'b0;
            if (bus.done === 1'b1) begin
                lat = c;
                p   = bus.prod;
                break;
            end
            bus.a = rnd53() | 53'd1;
            bus.b = rnd53() | 53'd1;
        end
        n_cmp++;
        if (lat != 6 || p !== 106'd0) begin
            n_err++;
            $display("FAIL zero_toggle lat=%0d prod=%h required lat=6 prod=0", lat, p);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_timing();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_reset_wins();
        test_cross_and_random();
        test_zero_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
